// File: rtl/psum_buff_ctrl.sv
// Partial-sum buffer controller: sequences zero-fill, multi-pass accumulation and
// drain of a double-banked partial-sum FIFO pair for one PE column.
module psum_buff_ctrl #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DEPTH  = 62,
    parameter int unsigned PASS_W = 8,
    parameter int unsigned ROW_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_row_len,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic              pe_valid,
    output logic              pe_ready,
    output logic              p_init,
    output logic              p_valid_data,
    output logic              p_write_zero,
    output logic              odd_cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [ROW_W-1:0]  row_idx,
    output logic [PASS_W-1:0] pass_idx
);

    localparam logic [CNT_W-1:0]  CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] PassOne = {{(PASS_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]  RowOne  = {{(ROW_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StInit, StAccum, StGap, StFlush} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  row_len_q, row_len_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [CNT_W-1:0]  beat_q, beat_d;      // init-cycle count in INIT, beat count in ACCUM
    logic [1:0]        gap_q, gap_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              odd_q, odd_d;
    logic              drain_q, drain_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              p_init_q, busy_q;

    logic cfg_ok, accept, beat_last, pass_last, row_last, drain_last, gap_done, row_start;

    assign cfg_ok = (cfg_row_len != '0) && (cfg_row_len <= CNT_W'(DEPTH)) &&
                    (cfg_passes != '0) && (cfg_rows != '0);

    assign pe_ready   = (state_q == StAccum);
    assign accept     = pe_ready & pe_valid;
    assign beat_last  = (beat_q == row_len_q - CntOne);
    assign pass_last  = (pass_q == passes_q - PassOne);
    assign row_last   = (row_q == rows_q - RowOne);
    assign gap_done   = (gap_q == 2'd2);
    assign drain_last = drain_q && (drain_cnt_q == row_len_q - CntOne);

    // Main sequencer: next state, counters and bank select.
    always_comb begin
        state_d   = state_q;
        row_len_d = row_len_q;
        passes_d  = passes_q;
        rows_d    = rows_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        pass_d    = pass_q;
        row_d     = row_q;
        odd_d     = odd_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        row_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        row_len_d = cfg_row_len;
                        passes_d  = cfg_passes;
                        rows_d    = cfg_rows;
                        beat_d    = '0;
                        pass_d    = '0;
                        row_d     = '0;
                        state_d   = StInit;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StInit: begin
                if (beat_last) begin
                    beat_d  = '0;
                    pass_d  = '0;
                    row_d   = '0;
                    odd_d   = 1'b0;
                    state_d = StAccum;
                end else begin
                    beat_d = beat_q + CntOne;
                end
            end
            StAccum: begin
                if (accept) begin
                    if (beat_last) begin
                        beat_d  = '0;
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        beat_d = beat_q + CntOne;
                    end
                end
            end
            StGap: begin
                if (!gap_done) begin
                    gap_d = gap_q + 2'd1;
                end else if (!pass_last) begin
                    pass_d  = pass_q + PassOne;
                    state_d = StAccum;
                end else if (!drain_q || drain_last) begin
                    // Bank swap waits for any running drain so it never toggles mid-drain.
                    row_start = 1'b1;
                    odd_d     = ~odd_q;
                    pass_d    = '0;
                    if (row_last) begin
                        state_d = StFlush;
                    end else begin
                        row_d   = row_q + RowOne;
                        state_d = StAccum;
                    end
                end
            end
            StFlush: begin
                if (drain_last) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Drain engine: runs row_len cycles after each completed row, independent of PE flow.
    always_comb begin
        drain_d     = drain_q;
        drain_cnt_d = drain_cnt_q;
        if (row_start) begin
            drain_d     = 1'b1;
            drain_cnt_d = '0;
        end else if (drain_q) begin
            if (drain_last) begin
                drain_d     = 1'b0;
                drain_cnt_d = '0;
            end else begin
                drain_cnt_d = drain_cnt_q + CntOne;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_len_q   <= '0;
            passes_q    <= '0;
            rows_q      <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            pass_q      <= '0;
            row_q       <= '0;
            odd_q       <= 1'b0;
            drain_q     <= 1'b0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            p_init_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_len_q   <= row_len_d;
            passes_q    <= passes_d;
            rows_q      <= rows_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            pass_q      <= pass_d;
            row_q       <= row_d;
            odd_q       <= odd_d;
            drain_q     <= drain_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            p_init_q    <= (state_d == StInit);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign p_valid_data = accept;
    assign p_init       = p_init_q;
    assign p_write_zero = drain_q;
    assign odd_cnt      = odd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign row_idx      = row_q;
    assign pass_idx     = pass_q;

endmodule

// File: tb/tb_psum_buff_ctrl.sv
// Directed testbench for psum_buff_ctrl.
module tb_psum_buff_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_row_len = '0;
    logic [7:0] cfg_passes = '0;
    logic [7:0] cfg_rows = '0;
    logic       pe_valid = 1'b0;
    logic       pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err;
    logic [7:0] row_idx, pass_idx;

    psum_buff_ctrl #(.CNT_W(8), .DEPTH(62), .PASS_W(8), .ROW_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_row_len  (cfg_row_len),
        .cfg_passes   (cfg_passes),
        .cfg_rows     (cfg_rows),
        .pe_valid     (pe_valid),
        .pe_ready     (pe_ready),
        .p_init       (p_init),
        .p_valid_data (p_valid_data),
        .p_write_zero (p_write_zero),
        .odd_cnt      (odd_cnt),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .row_idx      (row_idx),
        .pass_idx     (pass_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Per-job statistics gathered by run_job.
    int          n_init, n_beats, n_wz, n_done, done_cycle, busy_after;
    int          ov_iv, ov_iw, ov_vw, n_drains, max_row, max_pass;
    logic        drain_odd [8];
    logic        odd_first_beat;
    bit          seen_beat;
    logic [31:0] v_init, v_pv, v_rdy, v_wz, v_done, v_busy, v_odd;

    // Launch a job and observe it for 'budget' cycles; cycle 0 is the start cycle.
    task automatic run_job(input int rl, input int ps, input int rw, input bit toggle,
                           input bit inject, input int budget);
        logic prev_wz;
        n_init = 0; n_beats = 0; n_wz = 0; n_done = 0; done_cycle = -1; busy_after = 0;
        ov_iv = 0; ov_iw = 0; ov_vw = 0; n_drains = 0; max_row = 0; max_pass = 0;
        seen_beat = 0; odd_first_beat = 1'bx; prev_wz = 1'b0;
        v_init = '0; v_pv = '0; v_rdy = '0; v_wz = '0; v_done = '0; v_busy = '0; v_odd = '0;
        for (int i = 0; i < 8; i++) drain_odd[i] = 1'b0;
        @(posedge clk); #1;
        cfg_row_len = 8'(rl); cfg_passes = 8'(ps); cfg_rows = 8'(rw);
        for (int c = 0; c < budget; c++) begin
            start = (c == 0) || (inject && c == 6);
            if (inject && c == 6) begin
                cfg_row_len = 8'd2; cfg_passes = 8'd3; cfg_rows = 8'd2;
            end
            pe_valid = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (c < 32) begin
                v_init[c] = p_init; v_pv[c] = p_valid_data; v_rdy[c] = pe_ready;
                v_wz[c] = p_write_zero; v_done[c] = done; v_busy[c] = busy; v_odd[c] = odd_cnt;
            end
            if (p_init) n_init++;
            if (p_valid_data) begin
                n_beats++;
                if (!seen_beat) begin seen_beat = 1; odd_first_beat = odd_cnt; end
            end
            if (p_write_zero) n_wz++;
            if (p_init && p_valid_data) ov_iv++;
            if (p_init && p_write_zero) ov_iw++;
            if (p_valid_data && p_write_zero) ov_vw++;
            if (p_write_zero && !prev_wz) begin
                if (n_drains < 8) drain_odd[n_drains] = odd_cnt;
                n_drains++;
            end
            prev_wz = p_write_zero;
            if (busy && int'(row_idx) > max_row) max_row = int'(row_idx);
            if (busy && int'(pass_idx) > max_pass) max_pass = int'(pass_idx);
            if (done) begin
                n_done++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle >= 0 && c > done_cycle && busy) busy_after++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        pe_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err} !== 8'h00
            || row_idx !== 8'h00 || pass_idx !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_low: outputs %b row %0d pass %0d, required all zero",
                     {pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err},
                     row_idx, pass_idx);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err} !== 8'h00)
        begin
            n_fail++;
            $display("FAIL reset_release: outputs %b, required 00000000",
                     {pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err});
        end
    endtask

    // row_len=4, passes=1, rows=1, pe_valid held high: cycle-exact timeline.
    task automatic test_basic();
        run_job(4, 1, 1, 1'b0, 1'b0, 24);
        n_checks++;
        if (v_init !== 32'h0000_001E) begin
            n_fail++; $display("FAIL basic_p_init: got %h required 0000001e", v_init);
        end
        n_checks++;
        if (v_pv !== 32'h0000_01E0) begin
            n_fail++; $display("FAIL basic_p_valid_data: got %h required 000001e0", v_pv);
        end
        n_checks++;
        if (v_rdy !== 32'h0000_01E0) begin
            n_fail++; $display("FAIL basic_pe_ready: got %h required 000001e0", v_rdy);
        end
        n_checks++;
        if (v_wz !== 32'h0000_F000) begin
            n_fail++; $display("FAIL basic_p_write_zero: got %h required 0000f000", v_wz);
        end
        n_checks++;
        if (v_done !== 32'h0001_0000) begin
            n_fail++; $display("FAIL basic_done: got %h required 00010000", v_done);
        end
        n_checks++;
        if (v_busy !== 32'h0000_FFFE) begin
            n_fail++; $display("FAIL basic_busy: got %h required 0000fffe", v_busy);
        end
        n_checks++;
        if (v_odd !== 32'h00FF_F000) begin
            n_fail++; $display("FAIL basic_odd_cnt: got %h required 00fff000", v_odd);
        end
        n_checks++;
        if (odd_cnt !== 1'b1) begin
            n_fail++; $display("FAIL idle_odd_hold: got %b required 1", odd_cnt);
        end
    endtask

    // row_len=3, passes=2, rows=3 with pe_valid toggling every cycle.
    task automatic test_multi_pass();
        run_job(3, 2, 3, 1'b1, 1'b0, 120);
        n_checks++;
        if (n_done !== 1) begin
            n_fail++; $display("FAIL multi_done_count: got %0d required 1", n_done);
        end
        n_checks++;
        if (n_beats !== 18) begin
            n_fail++; $display("FAIL multi_beats: got %0d required 18", n_beats);
        end
        n_checks++;
        if (n_wz !== 9) begin
            n_fail++; $display("FAIL multi_write_zero: got %0d required 9", n_wz);
        end
        n_checks++;
        if (n_init !== 3) begin
            n_fail++; $display("FAIL multi_init: got %0d required 3", n_init);
        end
        n_checks++;
        if (odd_first_beat !== 1'b0) begin
            n_fail++; $display("FAIL multi_odd_first: got %b required 0", odd_first_beat);
        end
        n_checks++;
        if (n_drains !== 3 || drain_odd[0] !== 1'b1 || drain_odd[1] !== 1'b0
            || drain_odd[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_odd_seq: drains %0d odd %b%b%b required 3 drains odd 101",
                     n_drains, drain_odd[0], drain_odd[1], drain_odd[2]);
        end
        n_checks++;
        if (ov_vw == 0) begin
            n_fail++; $display("FAIL multi_drain_overlap: got %0d overlap cycles required >0", ov_vw);
        end
        n_checks++;
        if (max_row !== 2 || max_pass !== 1) begin
            n_fail++;
            $display("FAIL multi_indices: max row %0d pass %0d required 2 1", max_row, max_pass);
        end
        n_checks++;
        if (ov_iv !== 0 || ov_iw !== 0) begin
            n_fail++; $display("FAIL multi_exclusive: iv %0d iw %0d required 0 0", ov_iv, ov_iw);
        end
    endtask

    // Illegal configurations and the legal upper row length.
    task automatic test_cfg_err();
        int rl_t [4] = '{63, 4, 0, 4};
        int ps_t [4] = '{1, 0, 1, 1};
        int rw_t [4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cfg_row_len = 8'(rl_t[i]); cfg_passes = 8'(ps_t[i]); cfg_rows = 8'(rw_t[i]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_pulse[%0d]: cfg_err %b busy %b required 1 0", i, cfg_err, busy);
            end
            @(posedge clk); #1;
            n_checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_clear[%0d]: cfg_err %b busy %b required 0 0", i, cfg_err, busy);
            end
        end
        run_job(62, 1, 1, 1'b0, 1'b0, 200);
        n_checks++;
        if (n_init !== 62 || n_beats !== 62 || n_wz !== 62) begin
            n_fail++;
            $display("FAIL depth_counts: init %0d beats %0d wz %0d required 62 62 62",
                     n_init, n_beats, n_wz);
        end
        n_checks++;
        if (done_cycle !== 190) begin
            n_fail++; $display("FAIL depth_done_cycle: got %0d required 190", done_cycle);
        end
    endtask

    // row_len=1, passes=1, rows=2.
    task automatic test_short_rows();
        run_job(1, 1, 2, 1'b0, 1'b0, 20);
        n_checks++;
        if (done_cycle !== 11) begin
            n_fail++; $display("FAIL short_done_cycle: got %0d required 11", done_cycle);
        end
        n_checks++;
        if (n_init !== 1 || n_beats !== 2 || n_wz !== 2 || n_drains !== 2) begin
            n_fail++;
            $display("FAIL short_counts: init %0d beats %0d wz %0d drains %0d required 1 2 2 2",
                     n_init, n_beats, n_wz, n_drains);
        end
        n_checks++;
        if (ov_iv !== 0 || ov_iw !== 0) begin
            n_fail++; $display("FAIL short_exclusive: iv %0d iw %0d required 0 0", ov_iv, ov_iw);
        end
    endtask

    // Reset asserted during the drain of row 1, then a clean short job.
    task automatic test_reset_mid();
        bit   hit = 0;
        int   rises = 0;
        logic prev = 1'b0;
        @(posedge clk); #1;
        cfg_row_len = 8'd3; cfg_passes = 8'd1; cfg_rows = 8'd2;
        for (int c = 0; c < 60; c++) begin
            start = (c == 0);
            pe_valid = 1'b1;
            #1;
            if (p_write_zero && !prev) rises++;
            prev = p_write_zero;
            if (rises == 2) begin
                rst_n = 1'b0;
                #1;
                hit = 1;
                n_checks++;
                if ({pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done, cfg_err}
                    !== 8'h00 || row_idx !== 8'h00 || pass_idx !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_mid_outputs: got %b row %0d pass %0d required all zero",
                             {pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, done,
                              cfg_err}, row_idx, pass_idx);
                end
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL reset_mid_reach: second drain seen %0d required 1", 0);
        end
        @(negedge clk) rst_n = 1'b1;
        run_job(2, 1, 1, 1'b0, 1'b0, 16);
        n_checks++;
        if (done_cycle !== 10 || n_init !== 2 || n_beats !== 2 || n_wz !== 2) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: done %0d init %0d beats %0d wz %0d required 10 2 2 2",
                     done_cycle, n_init, n_beats, n_wz);
        end
    endtask

    // Start pulsed mid-job with a different configuration.
    task automatic test_back_to_back();
        run_job(4, 1, 1, 1'b0, 1'b1, 24);
        n_checks++;
        if (n_init !== 4 || n_beats !== 4 || n_wz !== 4) begin
            n_fail++;
            $display("FAIL b2b_counts: init %0d beats %0d wz %0d required 4 4 4",
                     n_init, n_beats, n_wz);
        end
        n_checks++;
        if (done_cycle !== 16 || n_done !== 1) begin
            n_fail++;
            $display("FAIL b2b_done: cycle %0d count %0d required 16 1", done_cycle, n_done);
        end
        n_checks++;
        if (busy_after !== 0) begin
            n_fail++; $display("FAIL b2b_no_restart: busy cycles %0d required 0", busy_after);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_pass();
        test_cfg_err();
        test_short_rows();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
